// File: rtl/alu_pkg.sv
// Shared ALU datapath types: result flag bundle and add/subtract op-mode encoding.
package alu_pkg;

  typedef struct packed {
    logic cout;
    logic overflow;
    logic zero;
  } alu_flags_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder; master drives operands and out_ready.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/adder_segment.sv
// SEG-bit ripple adder built from fulladder cells; combinational, no handshake.
// cmsb is the carry into the top bit, paired with cout for signed-overflow detection.
module adder_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);
  logic [SEG:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    fulladder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[SEG];
  assign cmsb = c[SEG-1];
endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell; purely combinational.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract, one SEG-bit carry segment per stage; result registered STAGES cycles after acceptance.
// Any output stall freezes every stage (in_ready = !out_valid || out_ready); bubbles are not squeezed.
module pipelined_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             reset,
  pipelined_adder_if.slave io
);
  localparam int STAGES = WIDTH / SEG;

  logic              adv;
  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];
  alu_flags_t        flags_q;

  logic              v_in   [STAGES];
  logic              c_in   [STAGES];
  logic              seg_co [STAGES];
  logic              seg_cm [STAGES];
  logic [WIDTH-1:0]  a_in   [STAGES];
  logic [WIDTH-1:0]  b_in   [STAGES];
  logic [WIDTH-1:0]  s_in   [STAGES];
  logic [WIDTH-1:0]  s_nxt  [STAGES];
  logic [SEG-1:0]    seg_sum[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Subtract is folded into an add: a + ~b + ~cin.
      assign v_in[k] = io.in_valid;
      assign a_in[k] = io.a;
      assign b_in[k] = (io.sub == OP_ADD) ? io.b : ~io.b;
      assign c_in[k] = (io.sub == OP_SUB) ? ~io.cin : io.cin;
      assign s_in[k] = '0;
    end else begin : g_body
      assign v_in[k] = v_q[k-1];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign s_in[k] = s_q[k-1];
    end

    adder_segment #(.SEG(SEG)) u_seg (
      .a    (a_in[k][k*SEG +: SEG]),
      .b    (b_in[k][k*SEG +: SEG]),
      .cin  (c_in[k]),
      .sum  (seg_sum[k]),
      .cout (seg_co[k]),
      .cmsb (seg_cm[k])
    );

    // Bits above the completed segments are still zero, so OR-ing in place is enough.
    assign s_nxt[k] = s_in[k] | (WIDTH'(seg_sum[k]) << (k * SEG));
  end

  assign adv = ~v_q[STAGES-1] | io.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q     <= '0;
      flags_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_in[k];
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_nxt[k];
        c_q[k] <= seg_co[k];
      end
      flags_q.cout     <= seg_co[STAGES-1];
      flags_q.overflow <= seg_co[STAGES-1] ^ seg_cm[STAGES-1];
      flags_q.zero     <= ~|s_nxt[STAGES-1];
    end
  end

  assign io.in_ready  = adv;
  assign io.out_valid = v_q[STAGES-1];
  assign io.sum       = s_q[STAGES-1];
  assign io.cout      = flags_q.cout;
  assign io.overflow  = flags_q.overflow;
  assign io.zero      = flags_q.zero;
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed 8/4 vectors and sequences, then random streams on 8/4, 32/8 and 8/8.
module tb_pipelined_adder;
  localparam int NOPS = 10000;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
    logic       z;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
    int          acc;
    int          s0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic        iv [3];
  logic [31:0] av [3];
  logic [31:0] bv [3];
  logic        cv [3];
  logic        sv [3];
  logic        rv [3];
  logic        ird[3];
  logic        ovd[3];
  logic [31:0] sm [3];
  logic        co [3];
  logic        of [3];
  logic        zr [3];

  int   wd [3];
  int   stg[3];
  exp_t q  [3][$];
  int   issued[3], done[3], stalls[3];
  logic seen[3], took[3];
  vec_t vt[9];
  exp_t e;
  logic [7:0] res[4];
  int   got, idx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder_if #(.WIDTH(8))  if0 ();
  pipelined_adder_if #(.WIDTH(32)) if1 ();
  pipelined_adder_if #(.WIDTH(8))  if2 ();

  pipelined_adder #(.WIDTH(8),  .SEG(4)) u_d0 (.clk(clk), .reset(rst), .io(if0.slave));
  pipelined_adder #(.WIDTH(32), .SEG(8)) u_d1 (.clk(clk), .reset(rst), .io(if1.slave));
  pipelined_adder #(.WIDTH(8),  .SEG(8)) u_d2 (.clk(clk), .reset(rst), .io(if2.slave));

  assign if0.in_valid = iv[0];  assign if0.a = av[0][7:0];  assign if0.b = bv[0][7:0];
  assign if0.cin = cv[0];       assign if0.sub = sv[0];     assign if0.out_ready = rv[0];
  assign if1.in_valid = iv[1];  assign if1.a = av[1];       assign if1.b = bv[1];
  assign if1.cin = cv[1];       assign if1.sub = sv[1];     assign if1.out_ready = rv[1];
  assign if2.in_valid = iv[2];  assign if2.a = av[2][7:0];  assign if2.b = bv[2][7:0];
  assign if2.cin = cv[2];       assign if2.sub = sv[2];     assign if2.out_ready = rv[2];

  assign ird[0] = if0.in_ready;  assign ovd[0] = if0.out_valid;  assign sm[0] = 32'(if0.sum);
  assign co[0] = if0.cout;       assign of[0] = if0.overflow;    assign zr[0] = if0.zero;
  assign ird[1] = if1.in_ready;  assign ovd[1] = if1.out_valid;  assign sm[1] = if1.sum;
  assign co[1] = if1.cout;       assign of[1] = if1.overflow;    assign zr[1] = if1.zero;
  assign ird[2] = if2.in_ready;  assign ovd[2] = if2.out_valid;  assign sm[2] = 32'(if2.sum);
  assign co[2] = if2.cout;       assign of[2] = if2.overflow;    assign zr[2] = if2.zero;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: exact integer arithmetic, then reduce to WIDTH bits and range-check signed result.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic is_sub);
    exp_t   r;
    longint one, ua, ub, sa, sb, u, s;
    one = 1;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = a[w-1] ? ua - (one << w) : ua;
    sb  = b[w-1] ? ub - (one << w) : ub;
    if (!is_sub) begin
      u    = ua + ub + longint'(ci);
      s    = sa + sb + longint'(ci);
      r.co = (u >= (one << w));
    end else begin
      u    = ua - ub - longint'(ci);
      s    = sa - sb - longint'(ci);
      r.co = (u >= 0);
    end
    r.s   = 32'(u & ((one << w) - 1));
    r.ov  = (s >= (one << (w - 1))) || (s < -(one << (w - 1)));
    r.z   = (r.s == 32'd0);
    r.acc = 0;
    r.s0  = 0;
    return r;
  endfunction

  function automatic logic [31:0] rnd(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return m;
      2:       return 32'd1 << (w - 1);
      default: return $urandom & m;
    endcase
  endfunction

  task automatic drive0(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic s);
    iv[0] = v; av[0] = {24'd0, a}; bv[0] = {24'd0, b}; cv[0] = ci; sv[0] = s;
  endtask

  initial begin
    wd  = '{8, 32, 8};
    stg = '{2, 4, 1};
    for (int i = 0; i < 3; i++) begin
      iv[i] = 0; av[i] = 0; bv[i] = 0; cv[i] = 0; sv[i] = 0; rv[i] = 1;
    end
    vt[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vt[2] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vt[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    vt[4] = '{8'h05, 8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0};
    vt[5] = '{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    vt[6] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vt[7] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vt[8] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};

    // Reset state
    #13;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d reset out_valid", i), ovd[i], 0);
      chk($sformatf("d%0d reset sum", i), sm[i], 0);
      chk($sformatf("d%0d reset cout", i), co[i], 0);
      chk($sformatf("d%0d reset overflow", i), of[i], 0);
      chk($sformatf("d%0d reset zero", i), zr[i], 0);
      chk($sformatf("d%0d reset in_ready", i), ird[i], 1);
    end
    @(negedge clk); rst = 0;
    repeat (2) @(negedge clk);

    // Directed vectors, one op at a time, fixed two-cycle latency
    for (int n = 0; n < 9; n++) begin
      drive0(1, vt[n].a, vt[n].b, vt[n].cin, vt[n].sub);
      @(negedge clk); iv[0] = 0; #1;
      chk($sformatf("vec%0d early out_valid", n), ovd[0], 0);
      @(negedge clk); #1;
      chk($sformatf("vec%0d out_valid", n), ovd[0], 1);
      chk($sformatf("vec%0d sum", n), sm[0], {24'd0, vt[n].s});
      chk($sformatf("vec%0d cout", n), co[0], vt[n].co);
      chk($sformatf("vec%0d overflow", n), of[0], vt[n].ov);
      chk($sformatf("vec%0d zero", n), zr[0], vt[n].z);
    end
    repeat (3) @(negedge clk);

    // Back-to-back stream at full throughput
    for (int t = 0; t < 6; t++) begin
      if (t < 4) drive0(1, 8'(t + 1), 8'(t + 1), 0, 0); else iv[0] = 0;
      #1;
      if (t >= 2) begin
        chk($sformatf("b2b t%0d out_valid", t), ovd[0], 1);
        chk($sformatf("b2b t%0d sum", t), sm[0], 32'(2 * (t - 1)));
      end
      @(negedge clk);
    end
    #1 chk("b2b drained", ovd[0], 0);
    repeat (2) @(negedge clk);

    // Same stream with a three-cycle output stall after the first result
    idx = 0; got = 0;
    for (int t = 0; t < 30 && got < 4; t++) begin
      rv[0] = !(t >= 2 && t <= 4);
      if (idx < 4) drive0(1, 8'(idx + 1), 8'(idx + 1), 0, 0); else iv[0] = 0;
      #1;
      if (t >= 2 && t <= 4) begin
        chk($sformatf("stall t%0d in_ready", t), ird[0], 0);
        chk($sformatf("stall t%0d out_valid", t), ovd[0], 1);
        chk($sformatf("stall t%0d sum held", t), sm[0], 32'h02);
      end
      if (ovd[0] && rv[0]) begin res[got] = sm[0][7:0]; got++; end
      if (iv[0] && ird[0]) idx++;
      @(negedge clk);
    end
    iv[0] = 0; rv[0] = 1;
    chk("stall result count", got, 4);
    for (int n = 0; n < 4; n++) chk($sformatf("stall result %0d", n), {24'd0, res[n]}, 32'(2 * (n + 1)));
    repeat (3) @(negedge clk);

    // Asynchronous reset with two ops in flight
    drive0(1, 8'h11, 8'h11, 0, 0);
    @(negedge clk); drive0(1, 8'h22, 8'h22, 0, 0);
    @(negedge clk); iv[0] = 0; #1;
    chk("pre-reset out_valid", ovd[0], 1);
    #1 rst = 1; #1;
    chk("async reset out_valid", ovd[0], 0);
    chk("async reset sum", sm[0], 0);
    chk("async reset in_ready", ird[0], 1);
    @(negedge clk); rst = 0;
    @(negedge clk); #1 chk("post-reset no stale", ovd[0], 0);
    drive0(1, 8'h10, 8'h20, 0, 0);
    @(negedge clk); iv[0] = 0; #1 chk("post-reset early", ovd[0], 0);
    @(negedge clk); #1;
    chk("post-reset out_valid", ovd[0], 1);
    chk("post-reset sum", sm[0], 32'h30);
    @(negedge clk); #1 chk("post-reset single result", ovd[0], 0);
    repeat (2) @(negedge clk);

    // Random streams on all three configurations with random backpressure
    for (int i = 0; i < 3; i++) begin
      issued[i] = 0; done[i] = 0; stalls[i] = 0; seen[i] = 0; took[i] = 1; iv[i] = 0;
    end
    for (int t = 0; t < 40000 && !(done[0] >= NOPS && done[1] >= NOPS && done[2] >= NOPS); t++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!iv[i] || took[i]) begin
          iv[i] = (issued[i] < NOPS) && ($urandom_range(0, 9) < 7);
          av[i] = rnd(wd[i]);
          bv[i] = rnd(wd[i]);
          cv[i] = 1'($urandom_range(0, 1));
          sv[i] = 1'($urandom_range(0, 1));
        end
        rv[i] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("d%0d in_ready", i), ird[i], !ovd[i] || rv[i]);
        if (ovd[i]) begin
          if (q[i].size() == 0) begin
            chk($sformatf("d%0d spurious out_valid", i), ovd[i], 0);
          end else begin
            e = q[i][0];
            chk($sformatf("d%0d sum", i), sm[i], e.s);
            chk($sformatf("d%0d cout", i), co[i], e.co);
            chk($sformatf("d%0d overflow", i), of[i], e.ov);
            chk($sformatf("d%0d zero", i), zr[i], e.z);
            if (!seen[i]) chk($sformatf("d%0d latency", i), cyc - e.acc - (stalls[i] - e.s0), stg[i] - 1);
            seen[i] = 1;
            if (rv[i]) begin
              void'(q[i].pop_front());
              seen[i] = 0;
              done[i]++;
            end
          end
          if (!rv[i]) stalls[i]++;
        end
        took[i] = iv[i] && ird[i];
        if (took[i]) begin
          e = model(wd[i], av[i], bv[i], cv[i], sv[i]);
          e.acc = cyc + 1;
          e.s0  = stalls[i];
          q[i].push_back(e);
          issued[i]++;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d random ops completed", i), done[i], NOPS);
      chk($sformatf("d%0d leftover expected", i), q[i].size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
